traffic_conflict_monitor: RTL
=============================

Name: traffic_conflict_monitor

Overview:
- Independent safety checker on the receiving side of the four-head traffic light bus (n/s/e/w, 3-bit one-hot codes per head).
- Samples the light codes every clk and checks encoding, conflicts, pairing, legal colour sequence, minimum dwell times and stalls.
- Latches the first fault and drives a fail-safe flash_red request to the lamp driver stage.

Parameters:
- MIN_GREEN, 6, minimum consecutive cycles a green must be held before leaving it.
- MIN_YELLOW, 4, minimum consecutive cycles a yellow must be held before leaving it.
- MAX_STALL, 16, number of consecutive sampling edges with all heads unchanged that raises a stall fault.
- CNT_W, 8, width of the dwell, stall and rotation counters; all saturate except cycle_count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- n_light  input  3  north head code: GREEN 3'b001, YELLOW 3'b010, RED 3'b100.
- s_light  input  3  south head code, same encoding.
- e_light  input  3  east head code, same encoding.
- w_light  input  3  west head code, same encoding.
- clear_fault  input  1  synchronous request to release the latched fault.
- fault  output  1  latched fault flag.
- fault_code  output  3  code of the first fault: 0 none, 1 invalid, 2 conflict, 3 mismatch, 4 illegal transition, 5 min-dwell, 6 stall.
- flash_red  output  1  fail-safe request; equals fault.
- cycle_count  output  CNT_W  count of NS red-to-green entries, wraps.

Behaviour:
- Reset (async): fault=0, fault_code=0, flash_red=0, cycle_count=0. prev_ns=prev_ew=RED. Dwell counters=0, stall counter=0, armed_ns=armed_ew=0.
- Sampling and latency:
  - Inputs are checked at each rising edge k.
  - Transition checks compare the edge-k value against prev, the value stored at edge k-1.
  - A violation present at edge k gives fault=1 and a valid fault_code immediately after edge k (1-cycle registered latency).
- Axis values:
  - NS axis value = n_light; EW axis value = e_light.
  - s_light and w_light are used for mismatch checking only.
- Check 1, invalid: any head not exactly one of 001/010/100.
- Check 2, conflict: n_light!=RED and e_light!=RED at the same time; both are valid codes.
- Check 3, mismatch: n_light!=s_light or e_light!=w_light.
- Check 4, illegal transition (per axis, on change only):
  - Legal changes: GREEN->YELLOW, YELLOW->RED, RED->GREEN.
  - Illegal changes: GREEN->RED, YELLOW->GREEN, RED->YELLOW.
- Check 5, min-dwell (per axis, on change, only if that axis is armed):
  - Leaving GREEN with dwell<MIN_GREEN is a fault.
  - Leaving YELLOW with dwell<MIN_YELLOW is a fault.
- Dwell counter:
  - Set to 1 on a change, otherwise incremented; saturates at all-ones.
  - The dwell value checked is the count before the update at that edge.
  - armed_x is set at the first change of that axis after reset, so a partial first phase is never dwell-checked.
- Check 6, stall:
  - stall_cnt is set to 0 when any of the four heads differs from its previous sample, otherwise incremented (saturating).
  - Fault when stall_cnt reaches MAX_STALL.
- Priority: with several violations at one edge, the lowest code number is recorded.
- Latching:
  - Once fault=1, fault_code is frozen at the first fault until cleared.
  - Checks and history (prev, dwell, stall, cycle_count) keep updating while faulted.
- clear_fault:
  - At edge k with no violation at edge k: fault, fault_code and flash_red return to 0.
  - If a violation exists at the same edge, the fault wins: fault stays 1 and fault_code takes the new code.
- History on invalid codes: prev is updated only for valid codes. Checks 4 and 5 are skipped on an axis whose current or previous code is invalid.
- cycle_count: increments, with wrap, on each NS RED->GREEN change. This includes the first green after reset, because prev resets to RED.
- Reset mid-operation: everything returns to reset values asynchronously. The next sampled phase is treated as a partial phase (not armed).

Test Plan:
- Legal traffic: drive NS G6/Y4 then EW G6/Y4 (the other axis RED) for 3 rotations starting at NS green -> fault=0 throughout, cycle_count=3.
- Conflict: from a legal NS green, set e=w=3'b001 for 1 cycle -> after that edge fault=1, fault_code=2, flash_red=1. Further violations keep code 2.
- Invalid code: w_light=3'b011 while all else legal -> fault_code=1. Mixing it with a simultaneous conflict still gives code 1.
- Dwell and transition: after one full armed rotation, hold NS green 3 cycles then yellow -> fault_code=5. Separately, NS GREEN->RED directly -> fault_code=4.
- Stall: hold NS green/EW red unchanged -> fault asserts at the 16th consecutive unchanged edge with fault_code=6, not earlier.
- Clear and reset:
  - clear_fault=1 with legal inputs -> fault=0, code=0 next edge.
  - clear_fault=1 during an active conflict -> fault stays 1.
  - Assert rst mid-fault -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Independent safety checker for the four-head traffic light bus. Every
// rising clk edge it samples the north/south/east/west light codes and looks
// for the following faults:
//   - invalid encodings
//   - NS/EW conflicts
//   - paired-head mismatches
//   - illegal colour steps
//   - green/yellow phases that end too early
//   - a bus that has stopped changing
// The first fault is latched and mirrored on flash_red as a fail-safe
// request to the lamp driver stage.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   n_light      north head code (GREEN 001, YELLOW 010, RED 100)
//   s_light      south head code, must match north
//   e_light      east head code
//   w_light      west head code, must match east
//   clear_fault  synchronous request to release the latched fault
//   fault        latched fault flag
//   fault_code   first fault: 0 none, 1 invalid, 2 conflict, 3 mismatch,
//                4 illegal transition, 5 min-dwell, 6 stall
//   flash_red    fail-safe request, identical to fault
//   cycle_count  number of NS red-to-green entries, wrapping
// ---------------------------------------------------------------------------
module traffic_conflict_monitor #(
   parameter int MIN_GREEN  = 6,
   parameter int MIN_YELLOW = 4,
   parameter int MAX_STALL  = 16,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       n_light,
   input  logic [2:0]       s_light,
   input  logic [2:0]       e_light,
   input  logic [2:0]       w_light,
   input  logic             clear_fault,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic             flash_red,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [2:0] GREEN  = 3'b001;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] RED    = 3'b100;

   localparam logic [CNT_W-1:0] MIN_GREEN_C  = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] MAX_STALL_C  = CNT_W'(MAX_STALL);

   typedef enum logic [2:0] {
      F_NONE     = 3'd0,
      F_INVALID  = 3'd1,
      F_CONFLICT = 3'd2,
      F_MISMATCH = 3'd3,
      F_ILLEGAL  = 3'd4,
      F_DWELL    = 3'd5,
      F_STALL    = 3'd6
   } fault_e;

   function automatic logic is_valid(input logic [2:0] code);
      return (code == GREEN) || (code == YELLOW) || (code == RED);
   endfunction

   function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
      return ((from == GREEN)  && (to == YELLOW)) ||
             ((from == YELLOW) && (to == RED))    ||
             ((from == RED)    && (to == GREEN));
   endfunction

   // The dwell compared here is the count accumulated before this edge's update.
   function automatic logic left_early(input logic [2:0] from, input logic [CNT_W-1:0] dwell);
      return ((from == GREEN)  && (dwell < MIN_GREEN_C)) ||
             ((from == YELLOW) && (dwell < MIN_YELLOW_C));
   endfunction

   logic [2:0]       prev_ns, prev_ew;
   logic [11:0]      prev_raw;
   logic [CNT_W-1:0] dwell_ns, dwell_ew, stall_cnt;
   logic             armed_ns, armed_ew;
   fault_e           code_q;

   logic             ns_change, ew_change;
   logic             bad_invalid, bad_conflict, bad_mismatch;
   logic             bad_illegal, bad_dwell, bad_stall;
   logic [CNT_W-1:0] dwell_ns_next, dwell_ew_next, stall_next;
   fault_e           viol_code;

   // Per-sample checks. An axis only "changes" when its new code is valid, so an
   // invalid sample never feeds the transition or dwell checks, and prev_ns and
   // prev_ew only ever hold valid codes.
   always_comb begin
      ns_change    = is_valid(n_light) && (n_light != prev_ns);
      ew_change    = is_valid(e_light) && (e_light != prev_ew);

      bad_invalid  = !is_valid(n_light) || !is_valid(s_light) ||
                     !is_valid(e_light) || !is_valid(w_light);
      bad_conflict = is_valid(n_light) && is_valid(e_light) &&
                     (n_light != RED) && (e_light != RED);
      bad_mismatch = (n_light != s_light) || (e_light != w_light);
      bad_illegal  = (ns_change && !legal_step(prev_ns, n_light)) ||
                     (ew_change && !legal_step(prev_ew, e_light));
      bad_dwell    = (ns_change && armed_ns && left_early(prev_ns, dwell_ns)) ||
                     (ew_change && armed_ew && left_early(prev_ew, e_dwell_sel(dwell_ew)));

      dwell_ns_next = ns_change ? CNT_W'(1) : ((&dwell_ns) ? dwell_ns : dwell_ns + 1'b1);
      dwell_ew_next = ew_change ? CNT_W'(1) : ((&dwell_ew) ? dwell_ew : dwell_ew + 1'b1);

      if ({n_light, s_light, e_light, w_light} != prev_raw)
         stall_next = '0;
      else
         stall_next = (&stall_cnt) ? stall_cnt : stall_cnt + 1'b1;
      bad_stall = (stall_next >= MAX_STALL_C);

      // Later assignments override earlier ones, so the lowest code wins.
      viol_code = F_NONE;
      if (bad_stall)    viol_code = F_STALL;
      if (bad_dwell)    viol_code = F_DWELL;
      if (bad_illegal)  viol_code = F_ILLEGAL;
      if (bad_mismatch) viol_code = F_MISMATCH;
      if (bad_conflict) viol_code = F_CONFLICT;
      if (bad_invalid)  viol_code = F_INVALID;
   end

   function automatic logic [CNT_W-1:0] e_dwell_sel(input logic [CNT_W-1:0] d);
      return d;
   endfunction

   // History and fault latch. The history keeps tracking the bus while the
   // monitor is faulted, so a release via clear_fault resumes with a correct
   // picture of the current phase. A new violation that coincides with
   // clear_fault re-latches with the new code instead of clearing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_ns     <= RED;
         prev_ew     <= RED;
         prev_raw    <= {RED, RED, RED, RED};
         dwell_ns    <= '0;
         dwell_ew    <= '0;
         stall_cnt   <= '0;
         armed_ns    <= 1'b0;
         armed_ew    <= 1'b0;
         cycle_count <= '0;
         fault       <= 1'b0;
         code_q      <= F_NONE;
      end else begin
         prev_raw  <= {n_light, s_light, e_light, w_light};
         stall_cnt <= stall_next;
         dwell_ns  <= dwell_ns_next;
         dwell_ew  <= dwell_ew_next;
         if (is_valid(n_light)) prev_ns <= n_light;
         if (is_valid(e_light)) prev_ew <= e_light;
         if (ns_change) armed_ns <= 1'b1;
         if (ew_change) armed_ew <= 1'b1;
         if (ns_change && (prev_ns == RED) && (n_light == GREEN))
            cycle_count <= cycle_count + 1'b1;

         if (viol_code != F_NONE) begin
            fault <= 1'b1;
            if (!fault || clear_fault) code_q <= viol_code;
         end else if (clear_fault) begin
            fault  <= 1'b0;
            code_q <= F_NONE;
         end
      end
   end

   assign fault_code = code_q;
   assign flash_red  = fault;

endmodule
